// File: rtl/tcam_cfg_ctrl_pkg.sv
// Shared definitions for the TCAM configuration sequencer: register map, op codes, status bits, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tcam_cfg_pkg;

    // Register byte offsets within the iomem window
    localparam logic [7:0] OFF_KEY0   = 8'h00;
    localparam logic [7:0] OFF_KEY1   = 8'h04;
    localparam logic [7:0] OFF_KEY2   = 8'h08;
    localparam logic [7:0] OFF_KEY3   = 8'h0C;
    localparam logic [7:0] OFF_ACT0   = 8'h10;
    localparam logic [7:0] OFF_ACT1   = 8'h14;
    localparam logic [7:0] OFF_CMD    = 8'h20;
    localparam logic [7:0] OFF_STATUS = 8'h24;

    // CMD field positions
    localparam int CMD_MASK_BIT = 8;
    localparam int CMD_OP_LSB   = 9;
    localparam int CMD_GO_BIT   = 31;

    // STATUS bit positions
    localparam int STAT_BUSY_BIT = 0;
    localparam int STAT_ERR_BIT  = 1;
    localparam int STAT_DONE_BIT = 2;
    localparam int STAT_CNT_LSB  = 8;

    typedef enum logic [1:0] {
        OP_NOP  = 2'd0,
        OP_TCAM = 2'd1,
        OP_ACT  = 2'd2,
        OP_DEF  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    // Merge a 32-bit write into an existing word honouring byte strobes
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/tcam_cfg_ctrl_if.sv
// PicoRV32 iomem bus bundle between the CPU (master) and the config sequencer (slave).
// Latency: n/a (wiring only).
// Backpressure: master holds valid until the slave returns a one-cycle ready pulse.
interface tcam_cfg_ctrl_if;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;

    modport master (
        output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        input  iomem_ready, iomem_rdata
    );

    modport slave (
        input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        output iomem_ready, iomem_rdata
    );
endinterface

// File: rtl/tcam_cfg_ctrl_seq.sv
// Commit sequencer: captures a command plus staged data, pulses one write enable, then holds a settle window.
// Latency: pulse one cycle after acceptance; busy for 1 + SETTLE_CYCLES cycles after acceptance.
// Backpressure: none internally; caller must only assert cmd_go while busy is low.
module tcam_cfg_seq
    import tcam_cfg_pkg::*;
#(
    parameter int KEY_W         = 128,
    parameter int IDX_W         = 4,
    parameter int ACTION_W      = 64,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                cmd_go,
    input  logic [IDX_W-1:0]    cmd_idx,
    input  logic                cmd_is_mask,
    input  op_e                 cmd_op,
    input  logic [KEY_W-1:0]    key_stage,
    input  logic [ACTION_W-1:0] act_stage,
    output logic                busy,
    output logic                done_set,
    output logic [7:0]          commit_cnt,
    output logic [IDX_W-1:0]    tcam_wr_addr,
    output logic                tcam_wr_is_mask,
    output logic [KEY_W-1:0]    tcam_wr_data,
    output logic                tcam_wr_en,
    output logic                action_wr_en,
    output logic [IDX_W-1:0]    action_wr_addr,
    output logic [ACTION_W-1:0] action_wr_data,
    output logic                action_wr_default,
    output logic [ACTION_W-1:0] action_default_data
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    op_e              op_q;

    // State and settle counter registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: IDLE -> ISSUE (one pulse cycle) -> HOLD (settle) -> IDLE
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_go) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                state_d = ST_HOLD;
                cnt_d   = '0;
            end
            ST_HOLD: begin
                if (cnt_q == CNT_LAST) begin
                    state_d  = ST_IDLE;
                    done_set = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Completed-commit counter, wraps naturally at 8 bits
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) commit_cnt <= '0;
        else if (done_set) commit_cnt <= commit_cnt + 8'd1;
    end

    // Capture command and staged data at acceptance so later staging writes cannot disturb them
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_q                <= OP_NOP;
            tcam_wr_addr        <= '0;
            tcam_wr_is_mask     <= 1'b0;
            tcam_wr_data        <= '0;
            action_wr_addr      <= '0;
            action_wr_data      <= '0;
            action_default_data <= '0;
        end else if (state_q == ST_IDLE && cmd_go) begin
            op_q <= cmd_op;
            case (cmd_op)
                OP_TCAM: begin
                    tcam_wr_addr    <= cmd_idx;
                    tcam_wr_is_mask <= cmd_is_mask;
                    tcam_wr_data    <= key_stage;
                end
                OP_ACT: begin
                    action_wr_addr <= cmd_idx;
                    action_wr_data <= act_stage;
                end
                OP_DEF:  action_default_data <= act_stage;
                default: ;
            endcase
        end
    end

    // Pulses come straight off the state register, so reset kills them immediately
    assign busy              = (state_q != ST_IDLE);
    assign tcam_wr_en        = (state_q == ST_ISSUE) && (op_q == OP_TCAM);
    assign action_wr_en      = (state_q == ST_ISSUE) && (op_q == OP_ACT);
    assign action_wr_default = (state_q == ST_ISSUE) && (op_q == OP_DEF);

endmodule

// File: rtl/tcam_cfg_ctrl.sv
// iomem register block staging TCAM keys/masks and actions, committed atomically through tcam_cfg_seq.
// Latency: one-cycle ready pulse per access; write pulse one cycle after an accepted CMD. Optional TCAM_CFG_IRQ_EN adds irq_done.
// Backpressure: never stalls the bus; a CMD arriving while busy is acknowledged, dropped and flagged in STATUS.err.
module tcam_cfg_ctrl
    import tcam_cfg_pkg::*;
#(
    parameter int         KEY_W         = 128,
    parameter int         ENTRIES       = 16,
    parameter int         IDX_W         = $clog2(ENTRIES),
    parameter int         ACTION_W      = 64,
    parameter logic [7:0] BASE_HI       = 8'h04,
    parameter int         SETTLE_CYCLES = 2
) (
    input  logic                clk,
    input  logic                resetn,
    tcam_cfg_ctrl_if.slave      bus,
    output logic [IDX_W-1:0]    tcam_wr_addr,
    output logic                tcam_wr_is_mask,
    output logic [KEY_W-1:0]    tcam_wr_data,
    output logic                tcam_wr_en,
    output logic                action_wr_en,
    output logic [IDX_W-1:0]    action_wr_addr,
    output logic [ACTION_W-1:0] action_wr_data,
    output logic                action_wr_default,
    output logic [ACTION_W-1:0] action_default_data
`ifdef TCAM_CFG_IRQ_EN
    ,
    output logic                irq_done
`endif
);

    localparam int KEY_WORDS = KEY_W / 32;
    localparam int ACT_WORDS = ACTION_W / 32;

    logic [KEY_WORDS-1:0][31:0] key_q;
    logic [ACT_WORDS-1:0][31:0] act_q;
    logic [7:0]  off;
    logic        sel, bus_wr, bus_rd;
    logic        cmd_form_ok, cmd_go, err_set, status_wr;
    logic        busy, done_set, err_q, done_q;
    logic [7:0]  commit_cnt;
    logic [31:0] status_word, rdata_d;
    logic        unused_addr_bits;

    assign off    = bus.iomem_addr[7:0];
    assign sel    = bus.iomem_valid && !bus.iomem_ready && (bus.iomem_addr[31:24] == BASE_HI);
    assign bus_wr = sel && (bus.iomem_wstrb != 4'h0);
    assign bus_rd = sel && (bus.iomem_wstrb == 4'h0);
    assign unused_addr_bits = ^bus.iomem_addr[23:8];

    // A well-formed CMD either starts a commit or, if one is in flight, raises err
    assign cmd_form_ok = bus_wr && (off == OFF_CMD) && (bus.iomem_wstrb == 4'hF) &&
                         bus.iomem_wdata[CMD_GO_BIT] &&
                         (bus.iomem_wdata[CMD_OP_LSB +: 2] != OP_NOP);
    assign cmd_go    = cmd_form_ok && !busy;
    assign err_set   = cmd_form_ok && busy;
    assign status_wr = bus_wr && (off == OFF_STATUS) && bus.iomem_wstrb[0];

    // Bus acknowledge: one ready pulse per selection, read data registered alongside
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus.iomem_ready <= 1'b0;
            bus.iomem_rdata <= '0;
        end else begin
            bus.iomem_ready <= sel;
            bus.iomem_rdata <= bus_rd ? rdata_d : '0;
        end
    end

    // Staging registers with byte-strobe writes; always writable, even mid-commit
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            key_q <= '0;
            act_q <= '0;
        end else if (bus_wr) begin
            for (int i = 0; i < KEY_WORDS; i++) begin
                if (off == 8'(OFF_KEY0 + 4*i))
                    key_q[i] <= apply_wstrb(key_q[i], bus.iomem_wdata, bus.iomem_wstrb);
            end
            for (int i = 0; i < ACT_WORDS; i++) begin
                if (off == 8'(OFF_ACT0 + 4*i))
                    act_q[i] <= apply_wstrb(act_q[i], bus.iomem_wdata, bus.iomem_wstrb);
            end
        end
    end

    // Sticky err/done flags; a set in the same cycle as a W1C wins
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            err_q  <= (err_q  & ~(status_wr & bus.iomem_wdata[STAT_ERR_BIT]))  | err_set;
            done_q <= (done_q & ~(status_wr & bus.iomem_wdata[STAT_DONE_BIT])) | done_set;
        end
    end

    // STATUS word assembly
    always_comb begin
        status_word = '0;
        status_word[STAT_BUSY_BIT]        = busy;
        status_word[STAT_ERR_BIT]         = err_q;
        status_word[STAT_DONE_BIT]        = done_q;
        status_word[STAT_CNT_LSB +: 8]    = commit_cnt;
    end

    // Read mux; CMD and unmapped offsets return zero
    always_comb begin
        rdata_d = '0;
        for (int i = 0; i < KEY_WORDS; i++) begin
            if (off == 8'(OFF_KEY0 + 4*i)) rdata_d = key_q[i];
        end
        for (int i = 0; i < ACT_WORDS; i++) begin
            if (off == 8'(OFF_ACT0 + 4*i)) rdata_d = act_q[i];
        end
        if (off == OFF_STATUS) rdata_d = status_word;
    end

`ifdef TCAM_CFG_IRQ_EN
    // Interrupt follows done one cycle later
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) irq_done <= 1'b0;
        else         irq_done <= done_q;
    end
`endif

    tcam_cfg_seq #(
        .KEY_W         (KEY_W),
        .IDX_W         (IDX_W),
        .ACTION_W      (ACTION_W),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_seq (
        .clk                 (clk),
        .resetn              (resetn),
        .cmd_go              (cmd_go),
        .cmd_idx             (bus.iomem_wdata[IDX_W-1:0]),
        .cmd_is_mask         (bus.iomem_wdata[CMD_MASK_BIT]),
        .cmd_op              (op_e'(bus.iomem_wdata[CMD_OP_LSB +: 2])),
        .key_stage           (key_q),
        .act_stage           (act_q),
        .busy                (busy),
        .done_set            (done_set),
        .commit_cnt          (commit_cnt),
        .tcam_wr_addr        (tcam_wr_addr),
        .tcam_wr_is_mask     (tcam_wr_is_mask),
        .tcam_wr_data        (tcam_wr_data),
        .tcam_wr_en          (tcam_wr_en),
        .action_wr_en        (action_wr_en),
        .action_wr_addr      (action_wr_addr),
        .action_wr_data      (action_wr_data),
        .action_wr_default   (action_wr_default),
        .action_default_data (action_default_data)
    );

endmodule
